// File: rtl/pll_reset_sequencer_pkg.sv
// Shared types and helpers for the PLL reset sequencer.
package pll_seq_pkg;

    // Sequencer states; encodings are visible on the state output.
    typedef enum logic [2:0] {
        ST_RESET     = 3'd0,
        ST_WAIT_LOCK = 3'd1,
        ST_STABLE    = 3'd2,
        ST_RUN       = 3'd3,
        ST_FAULT     = 3'd4
    } pll_seq_state_t;

    // Width of the shared cycle counter: enough for the largest of the
    // three cycle parameters plus one spare bit so it can never wrap.
    function automatic int cnt_width(input int a, input int b, input int c);
        int m;
        m = a;
        m = (b > m) ? b : m;
        m = (c > m) ? c : m;
        return $clog2(m) + 1;
    endfunction

endpackage

// File: rtl/pll_reset_sequencer_sync_2ff.sv
// Generic two-flop synchronizer, flops cleared by synchronous reset.
module sync_2ff #(
    parameter int WIDTH = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] meta_r;

    // Two register stages to resolve metastability of the async input.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            meta_r <= {WIDTH{1'b0}};
            q      <= {WIDTH{1'b0}};
        end else begin
            meta_r <= d;
            q      <= meta_r;
        end
    end

endmodule

// File: rtl/pll_reset_sequencer.sv
// PLL reset sequencer: pulses the PLL reset, waits for lock with timeout and
// retries, qualifies lock stability, then releases the system reset.
module pll_reset_sequencer
    import pll_seq_pkg::*;
#(
    parameter int RST_PULSE_CYCLES    = 16,
    parameter int LOCK_TIMEOUT_CYCLES = 50000,
    parameter int LOCK_STABLE_CYCLES  = 1024,
    parameter int MAX_RETRIES         = 3
) (
    input  logic       refclk,
    input  logic       rst_n,
    input  logic       pll_locked,
    input  logic       relock_req,
    output logic       pll_rst,
    output logic       sys_rst_n,
    output logic [2:0] state,
    output logic [1:0] retry_cnt,
    output logic       fault,
    output logic       lock_lost
);

    localparam int CW = cnt_width(RST_PULSE_CYCLES, LOCK_TIMEOUT_CYCLES, LOCK_STABLE_CYCLES);

    localparam logic [CW-1:0] RST_LAST    = CW'(RST_PULSE_CYCLES - 1);
    localparam logic [CW-1:0] TIMEOUT_LAST = CW'(LOCK_TIMEOUT_CYCLES - 1);
    localparam logic [CW-1:0] STABLE_LAST = CW'(LOCK_STABLE_CYCLES - 1);
    localparam logic [CW-1:0] CNT_ZERO    = {CW{1'b0}};
    localparam logic [CW-1:0] CNT_ONE     = {{(CW-1){1'b0}}, 1'b1};
    localparam logic [CW-1:0] CNT_FULL    = {CW{1'b1}};
    localparam logic [1:0]    RETRY_LIMIT = 2'(MAX_RETRIES);

    pll_seq_state_t state_r;
    pll_seq_state_t state_s;
    logic [CW-1:0]  cnt_r;
    logic [CW-1:0]  cnt_s;
    logic [CW-1:0]  cnt_inc_s;
    logic [1:0]     retry_s;
    logic [1:0]     retry_inc_s;
    logic           lock_lost_s;
    logic           pll_rst_s;
    logic           sys_rst_n_s;
    logic           fault_s;
    logic           lk;

    sync_2ff #(
        .WIDTH (1)
    ) u_lock_sync (
        .clk   (refclk),
        .rst_n (rst_n),
        .d     (pll_locked),
        .q     (lk)
    );

    assign state = state_r;

    // Next-state, counter and status logic for the whole sequence.
    always_comb begin
        state_s     = state_r;
        cnt_inc_s   = (cnt_r == CNT_FULL) ? cnt_r : (cnt_r + CNT_ONE);
        cnt_s       = cnt_inc_s;
        retry_inc_s = retry_cnt + 2'd1;
        retry_s     = retry_cnt;
        lock_lost_s = lock_lost;
        if (relock_req) begin
            // Restart request overrides every other transition.
            state_s     = ST_RESET;
            cnt_s       = CNT_ZERO;
            retry_s     = 2'd0;
            lock_lost_s = 1'b0;
        end else begin
            case (state_r)
                ST_RESET: begin
                    if (cnt_r == RST_LAST) begin
                        state_s = ST_WAIT_LOCK;
                        cnt_s   = CNT_ZERO;
                    end else begin
                        state_s = ST_RESET;
                    end
                end
                ST_WAIT_LOCK: begin
                    if (lk) begin
                        // Lock wins even on the timeout cycle.
                        state_s = ST_STABLE;
                        cnt_s   = CNT_ZERO;
                    end else if (cnt_r == TIMEOUT_LAST) begin
                        retry_s = retry_inc_s;
                        cnt_s   = CNT_ZERO;
                        state_s = (retry_inc_s == RETRY_LIMIT) ? ST_FAULT : ST_RESET;
                    end else begin
                        state_s = ST_WAIT_LOCK;
                    end
                end
                ST_STABLE: begin
                    if (!lk) begin
                        state_s = ST_WAIT_LOCK;
                        cnt_s   = CNT_ZERO;
                    end else if (cnt_r == STABLE_LAST) begin
                        state_s = ST_RUN;
                        cnt_s   = CNT_ZERO;
                        retry_s = 2'd0;
                    end else begin
                        state_s = ST_STABLE;
                    end
                end
                ST_RUN: begin
                    cnt_s = CNT_ZERO;
                    if (!lk) begin
                        state_s     = ST_RESET;
                        lock_lost_s = 1'b1;
                    end else begin
                        state_s = ST_RUN;
                    end
                end
                ST_FAULT: begin
                    state_s = ST_FAULT;
                    cnt_s   = CNT_ZERO;
                end
                default: begin
                    state_s = ST_RESET;
                    cnt_s   = CNT_ZERO;
                end
            endcase
        end
    end

    // Output decode of the upcoming state so outputs switch with the state.
    always_comb begin
        pll_rst_s   = 1'b1;
        sys_rst_n_s = 1'b0;
        fault_s     = 1'b0;
        case (state_s)
            ST_RESET:     pll_rst_s = 1'b1;
            ST_WAIT_LOCK: pll_rst_s = 1'b0;
            ST_STABLE:    pll_rst_s = 1'b0;
            ST_RUN: begin
                pll_rst_s   = 1'b0;
                sys_rst_n_s = 1'b1;
            end
            ST_FAULT: begin
                pll_rst_s = 1'b1;
                fault_s   = 1'b1;
            end
            default: pll_rst_s = 1'b1;
        endcase
    end

    // State, counter and registered outputs.
    always_ff @(posedge refclk) begin
        if (!rst_n) begin
            state_r   <= ST_RESET;
            cnt_r     <= CNT_ZERO;
            retry_cnt <= 2'd0;
            lock_lost <= 1'b0;
            pll_rst   <= 1'b1;
            sys_rst_n <= 1'b0;
            fault     <= 1'b0;
        end else begin
            state_r   <= state_s;
            cnt_r     <= cnt_s;
            retry_cnt <= retry_s;
            lock_lost <= lock_lost_s;
            pll_rst   <= pll_rst_s;
            sys_rst_n <= sys_rst_n_s;
            fault     <= fault_s;
        end
    end

endmodule

// File: tb/tb_pll_reset_sequencer.sv
// Self-checking bench for pll_reset_sequencer with short cycle parameters.
module tb_pll_reset_sequencer;

    localparam int RP = 4;
    localparam int LT = 20;
    localparam int LS = 8;
    localparam int MR = 2;

    localparam logic [2:0] S_RST = 3'd0;
    localparam logic [2:0] S_WT  = 3'd1;
    localparam logic [2:0] S_STB = 3'd2;
    localparam logic [2:0] S_RUN = 3'd3;
    localparam logic [2:0] S_FLT = 3'd4;

    logic       refclk = 1'b0;
    logic       rst_n;
    logic       pll_locked;
    logic       relock_req;
    logic       pll_rst;
    logic       sys_rst_n;
    logic [2:0] state;
    logic [1:0] retry_cnt;
    logic       fault;
    logic       lock_lost;

    int checks   = 0;
    int failures = 0;

    typedef struct {
        string      nm;
        logic [8:0] exp;
    } sb_t;
    sb_t sbq[$];

    typedef struct {
        int         ed;
        logic [8:0] exp;
        string      nm;
    } vec_t;
    vec_t tbl[8];

    always #5 refclk = ~refclk;

    pll_reset_sequencer #(
        .RST_PULSE_CYCLES    (RP),
        .LOCK_TIMEOUT_CYCLES (LT),
        .LOCK_STABLE_CYCLES  (LS),
        .MAX_RETRIES         (MR)
    ) dut (
        .refclk     (refclk),
        .rst_n      (rst_n),
        .pll_locked (pll_locked),
        .relock_req (relock_req),
        .pll_rst    (pll_rst),
        .sys_rst_n  (sys_rst_n),
        .state      (state),
        .retry_cnt  (retry_cnt),
        .fault      (fault),
        .lock_lost  (lock_lost)
    );

    function automatic logic [8:0] mk(input logic [2:0] st, input logic p, input logic s,
                                      input logic f, input logic l, input logic [1:0] rc);
        return {st, p, s, f, l, rc};
    endfunction

    // Apply inputs for the next edge, then wait until just after it.
    task automatic drive(input logic lk, input logic rq, input logic rn);
        pll_locked = lk;
        relock_req = rq;
        rst_n      = rn;
        @(posedge refclk);
        #1;
    endtask

    task automatic steps(input int n, input logic lk);
        repeat (n) drive(lk, 1'b0, 1'b1);
    endtask

    // Queue the expectation with the stimulus, compare after the edge.
    task automatic chk(input logic lk, input logic rq, input logic rn,
                       input string nm, input logic [8:0] ex);
        sb_t        e;
        logic [8:0] act;
        e.nm  = nm;
        e.exp = ex;
        sbq.push_back(e);
        drive(lk, rq, rn);
        e   = sbq.pop_front();
        act = {state, pll_rst, sys_rst_n, fault, lock_lost, retry_cnt};
        checks++;
        if (act !== e.exp) begin
            failures++;
            $display("FAIL %s: got st=%0d prst=%b srst=%b flt=%b ll=%b rc=%0d, want st=%0d prst=%b srst=%b flt=%b ll=%b rc=%0d",
                     e.nm, act[8:6], act[5], act[4], act[3], act[2], act[1:0],
                     e.exp[8:6], e.exp[5], e.exp[4], e.exp[3], e.exp[2], e.exp[1:0]);
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: time limit reached, checks=%0d failures=%0d", checks, failures);
        $fatal(1, "watchdog");
    end

    initial begin
        int ti;
        // Clean-lock vectors: edge number after reset release, expected outputs.
        tbl[0] = '{0,  mk(S_RST, 1'b1, 1'b0, 1'b0, 1'b0, 2'd0), "cl_edge0"};
        tbl[1] = '{2,  mk(S_RST, 1'b1, 1'b0, 1'b0, 1'b0, 2'd0), "cl_edge2"};
        tbl[2] = '{3,  mk(S_WT,  1'b0, 1'b0, 1'b0, 1'b0, 2'd0), "cl_wait"};
        tbl[3] = '{11, mk(S_WT,  1'b0, 1'b0, 1'b0, 1'b0, 2'd0), "cl_sync_lat"};
        tbl[4] = '{12, mk(S_STB, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0), "cl_stable"};
        tbl[5] = '{19, mk(S_STB, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0), "cl_pre_rel"};
        tbl[6] = '{20, mk(S_RUN, 1'b0, 1'b1, 1'b0, 1'b0, 2'd0), "cl_release"};
        tbl[7] = '{99, mk(S_RUN, 1'b0, 1'b1, 1'b0, 1'b0, 2'd0), "unused"};

        // Reset state.
        chk(1'b1, 1'b0, 1'b0, "reset0", mk(S_RST, 1'b1, 1'b0, 1'b0, 1'b0, 2'd0));
        chk(1'b0, 1'b1, 1'b0, "reset1", mk(S_RST, 1'b1, 1'b0, 1'b0, 1'b0, 2'd0));

        // Clean lock: pll_locked rises for edge 10 onward.
        ti = 0;
        for (int e = 0; e <= 20; e++) begin
            if (ti < 7 && tbl[ti].ed == e) begin
                chk((e >= 10), 1'b0, 1'b1, tbl[ti].nm, tbl[ti].exp);
                ti++;
            end else begin
                drive((e >= 10), 1'b0, 1'b1);
            end
        end

        // Loss in RUN: sys_rst_n drops on the third edge, pll_rst pulse of 4.
        chk(1'b0, 1'b0, 1'b1, "loss_e0",      mk(S_RUN, 1'b0, 1'b1, 1'b0, 1'b0, 2'd0));
        chk(1'b0, 1'b0, 1'b1, "loss_e1",      mk(S_RUN, 1'b0, 1'b1, 1'b0, 1'b0, 2'd0));
        chk(1'b0, 1'b0, 1'b1, "loss_e2",      mk(S_RST, 1'b1, 1'b0, 1'b0, 1'b1, 2'd0));
        steps(2, 1'b0);
        chk(1'b0, 1'b0, 1'b1, "loss_pulse",   mk(S_RST, 1'b1, 1'b0, 1'b0, 1'b1, 2'd0));
        chk(1'b0, 1'b0, 1'b1, "loss_wait",    mk(S_WT,  1'b0, 1'b0, 1'b0, 1'b1, 2'd0));
        steps(2, 1'b1);
        chk(1'b1, 1'b0, 1'b1, "loss_stable",  mk(S_STB, 1'b0, 1'b0, 1'b0, 1'b1, 2'd0));
        steps(7, 1'b1);
        chk(1'b1, 1'b0, 1'b1, "loss_release", mk(S_RUN, 1'b0, 1'b1, 1'b0, 1'b1, 2'd0));

        // Relock from RUN, one timeout, lock exactly on the timeout cycle,
        // then a one-cycle glitch in STABLE.
        chk(1'b0, 1'b1, 1'b1, "relock_run",   mk(S_RST, 1'b1, 1'b0, 1'b0, 1'b0, 2'd0));
        steps(3, 1'b0);
        chk(1'b0, 1'b0, 1'b1, "g_wait1",      mk(S_WT,  1'b0, 1'b0, 1'b0, 1'b0, 2'd0));
        steps(19, 1'b0);
        chk(1'b0, 1'b0, 1'b1, "g_timeout1",   mk(S_RST, 1'b1, 1'b0, 1'b0, 1'b0, 2'd1));
        steps(3, 1'b0);
        chk(1'b0, 1'b0, 1'b1, "g_wait2",      mk(S_WT,  1'b0, 1'b0, 1'b0, 1'b0, 2'd1));
        steps(17, 1'b0);
        chk(1'b1, 1'b0, 1'b1, "g_pre_to",     mk(S_WT,  1'b0, 1'b0, 1'b0, 1'b0, 2'd1));
        chk(1'b1, 1'b0, 1'b1, "g_pre_to2",    mk(S_WT,  1'b0, 1'b0, 1'b0, 1'b0, 2'd1));
        chk(1'b1, 1'b0, 1'b1, "lock_wins",    mk(S_STB, 1'b0, 1'b0, 1'b0, 1'b0, 2'd1));
        steps(4, 1'b1);
        chk(1'b0, 1'b0, 1'b1, "glitch_drop",  mk(S_STB, 1'b0, 1'b0, 1'b0, 1'b0, 2'd1));
        chk(1'b1, 1'b0, 1'b1, "glitch_sync",  mk(S_STB, 1'b0, 1'b0, 1'b0, 1'b0, 2'd1));
        chk(1'b1, 1'b0, 1'b1, "glitch_wait",  mk(S_WT,  1'b0, 1'b0, 1'b0, 1'b0, 2'd1));
        chk(1'b1, 1'b0, 1'b1, "glitch_restb", mk(S_STB, 1'b0, 1'b0, 1'b0, 1'b0, 2'd1));
        steps(6, 1'b1);
        chk(1'b1, 1'b0, 1'b1, "glitch_hold",  mk(S_STB, 1'b0, 1'b0, 1'b0, 1'b0, 2'd1));
        chk(1'b1, 1'b0, 1'b1, "glitch_rel",   mk(S_RUN, 1'b0, 1'b1, 1'b0, 1'b0, 2'd0));

        // Timeout twice into FAULT, hold there, then relock with lock available.
        chk(1'b0, 1'b1, 1'b1, "relock2",      mk(S_RST, 1'b1, 1'b0, 1'b0, 1'b0, 2'd0));
        steps(3, 1'b0);
        chk(1'b0, 1'b0, 1'b1, "f_wait1",      mk(S_WT,  1'b0, 1'b0, 1'b0, 1'b0, 2'd0));
        steps(19, 1'b0);
        chk(1'b0, 1'b0, 1'b1, "f_to1",        mk(S_RST, 1'b1, 1'b0, 1'b0, 1'b0, 2'd1));
        steps(3, 1'b0);
        chk(1'b0, 1'b0, 1'b1, "f_wait2",      mk(S_WT,  1'b0, 1'b0, 1'b0, 1'b0, 2'd1));
        steps(19, 1'b0);
        chk(1'b0, 1'b0, 1'b1, "f_fault",      mk(S_FLT, 1'b1, 1'b0, 1'b1, 1'b0, 2'd2));
        steps(10, 1'b1);
        chk(1'b1, 1'b0, 1'b1, "f_hold",       mk(S_FLT, 1'b1, 1'b0, 1'b1, 1'b0, 2'd2));
        chk(1'b1, 1'b1, 1'b1, "f_relock",     mk(S_RST, 1'b1, 1'b0, 1'b0, 1'b0, 2'd0));
        steps(3, 1'b1);
        chk(1'b1, 1'b0, 1'b1, "f_wait",       mk(S_WT,  1'b0, 1'b0, 1'b0, 1'b0, 2'd0));
        chk(1'b1, 1'b0, 1'b1, "f_stable",     mk(S_STB, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0));
        steps(7, 1'b1);
        chk(1'b1, 1'b0, 1'b1, "f_run",        mk(S_RUN, 1'b0, 1'b1, 1'b0, 1'b0, 2'd0));

        // Lose lock again, reach STABLE with lock_lost set, then reset one edge.
        steps(2, 1'b0);
        chk(1'b1, 1'b0, 1'b1, "m_loss",       mk(S_RST, 1'b1, 1'b0, 1'b0, 1'b1, 2'd0));
        steps(3, 1'b1);
        chk(1'b1, 1'b0, 1'b1, "m_wait",       mk(S_WT,  1'b0, 1'b0, 1'b0, 1'b1, 2'd0));
        chk(1'b1, 1'b0, 1'b1, "m_stable",     mk(S_STB, 1'b0, 1'b0, 1'b0, 1'b1, 2'd0));
        steps(2, 1'b1);
        chk(1'b1, 1'b0, 1'b0, "m_reset",      mk(S_RST, 1'b1, 1'b0, 1'b0, 1'b0, 2'd0));
        steps(2, 1'b1);
        chk(1'b1, 1'b0, 1'b1, "m_pulse",      mk(S_RST, 1'b1, 1'b0, 1'b0, 1'b0, 2'd0));
        chk(1'b1, 1'b0, 1'b1, "m_pulse_end",  mk(S_WT,  1'b0, 1'b0, 1'b0, 1'b0, 2'd0));
        chk(1'b1, 1'b0, 1'b1, "m_restable",   mk(S_STB, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0));
        steps(7, 1'b1);
        chk(1'b1, 1'b0, 1'b1, "m_run",        mk(S_RUN, 1'b0, 1'b1, 1'b0, 1'b0, 2'd0));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
